// File: rtl/fir_tap_accumulator.sv
// Folds NTAPS consecutive signed 32-bit beats into one output sample.
// The add can either saturate or wrap on signed overflow, and an overflow flag is kept for each sample.
module fir_tap_accumulator #(
  parameter int NTAPS    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_ovf_o,
  output logic        busy_o
);

  localparam int CW = $clog2(NTAPS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NTAPS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t        state_q;
  logic [31:0]   acc_q;
  logic          ovf_q;
  logic [CW-1:0] tap_cnt_q;
  logic [31:0]   out_data_q;
  logic          out_ovf_q;
  logic          out_valid_q;
  logic          in_ready_q;
  logic          busy_q;

  logic [31:0]   sum_d;
  logic [31:0]   acc_d;
  logic          ovf_hit_d;
  logic          ovf_d;

  always_comb begin
    sum_d     = acc_q + in_data_i;
    ovf_hit_d = (acc_q[31] == in_data_i[31]) && (sum_d[31] != acc_q[31]);
    acc_d     = sum_d;
    // Clamp toward the sign of the running sum; later beats continue from the clamp.
    if (SATURATE && ovf_hit_d) begin
      acc_d = acc_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    ovf_d = ovf_q | ovf_hit_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      tap_cnt_q   <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            acc_q     <= in_data_i;
            ovf_q     <= 1'b0;
            tap_cnt_q <= CW'(1);
            state_q   <= ACCUM;
            busy_q    <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid_i) begin
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            tap_cnt_q <= tap_cnt_q + CW'(1);
            if (tap_cnt_q == LAST_BEAT) begin
              out_data_q  <= acc_d;
              out_ovf_q   <= ovf_d;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          // in_ready only returns after the output handshake; there is no pass-through in the same cycle.
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            tap_cnt_q   <= '0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ovf_o   = out_ovf_q;
  assign busy_o      = busy_q;

endmodule
